// File: rtl/note_judge.sv
// note_judge: per-lane hit/miss judge feeding the score keeper.
// Each lane runs a two-state IDLE/WINDOW machine. A rising button edge inside
// the window is a hit. A window that runs out of ticks is a miss. A press outside
// any window is an optional stray miss. All outputs are registered, so a judgement
// appears one clock after the event that caused it.
module note_judge #(
    parameter int LANES          = 4,
    parameter int WINDOW_TICKS   = 12,
    parameter int CNT_W          = 4,
    parameter int PENALIZE_STRAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] btn,
    input  logic [LANES-1:0] note_spawn,
    input  logic             tick,
    output logic [LANES-1:0] noteAction,
    output logic [LANES-1:0] noteSuccessState,
    output logic [LANES-1:0] in_window
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_WINDOW = 1'b1
    } lane_state_t;

    // Counter value at which the next tick closes the window. The counter
    // therefore spans 0..WINDOW_TICKS-1, and the note stays hittable for
    // WINDOW_TICKS tick pulses.
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WINDOW_TICKS - 1);
    localparam logic             STRAY_MISS = (PENALIZE_STRAY != 0);

    logic [LANES-1:0] r_btn_prev;
    logic [LANES-1:0] w_press;

    // Previous button levels. These are cleared on reset, so edge detection
    // restarts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_prev <= '0;
        end else begin
            r_btn_prev <= btn;
        end
    end

    // A press is a rising edge only. A held button therefore counts once.
    assign w_press = btn & ~r_btn_prev;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            lane_state_t      r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_action;
            logic             r_success;

            // Lane judge. The action pulse defaults low every cycle. The
            // success flag changes only in a cycle that also raises the action
            // pulse. Otherwise it holds.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_action  <= 1'b0;
                    r_success <= 1'b0;
                end else begin
                    r_action <= 1'b0;
                    case (r_state)
                        ST_IDLE: begin
                            if (w_press[gi] && note_spawn[gi]) begin
                                // The note and the press arrive together. This
                                // is a hit, and it consumes the spawn.
                                r_action  <= 1'b1;
                                r_success <= 1'b1;
                            end else if (note_spawn[gi]) begin
                                r_state <= ST_WINDOW;
                                r_cnt   <= '0;
                            end else if (w_press[gi] && STRAY_MISS) begin
                                r_action  <= 1'b1;
                                r_success <= 1'b0;
                            end
                        end
                        ST_WINDOW: begin
                            if (w_press[gi]) begin
                                // A hit. This wins over an expiring tick. A
                                // simultaneous spawn opens a fresh window.
                                r_action  <= 1'b1;
                                r_success <= 1'b1;
                                r_cnt     <= '0;
                                if (!note_spawn[gi]) begin
                                    r_state <= ST_IDLE;
                                end
                            end else if (note_spawn[gi]) begin
                                // A new note displaces the unhit old one.
                                r_action  <= 1'b1;
                                r_success <= 1'b0;
                                r_cnt     <= '0;
                            end else if (tick) begin
                                if (r_cnt == LAST_CNT) begin
                                    r_action  <= 1'b1;
                                    r_success <= 1'b0;
                                    r_cnt     <= '0;
                                    r_state   <= ST_IDLE;
                                end else begin
                                    r_cnt <= r_cnt + CNT_W'(1);
                                end
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end

            assign noteAction[gi]       = r_action;
            assign noteSuccessState[gi] = r_success;
            assign in_window[gi]        = (r_state == ST_WINDOW);
        end
    endgenerate

endmodule

// File: tb/tb_note_judge.sv
// Testbench for note_judge. Two instances share the stimulus: one penalises
// stray presses and one ignores them. Both are compared every cycle against a
// note-level reference model. Fixed vectors, hand sequences and a randomized
// phase provide the stimulus.
module tb_note_judge;

    localparam int LANES = 4;
    localparam int WT    = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = '0;
    logic [3:0] spawn = '0;
    logic       tick = 1'b0;
    logic [3:0] act_p, succ_p, win_p;
    logic [3:0] act_n, succ_n, win_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    note_judge #(.LANES(LANES), .WINDOW_TICKS(WT), .CNT_W(4), .PENALIZE_STRAY(1)) dut_p (
        .clk(clk), .rst(rst), .btn(btn), .note_spawn(spawn), .tick(tick),
        .noteAction(act_p), .noteSuccessState(succ_p), .in_window(win_p)
    );

    note_judge #(.LANES(LANES), .WINDOW_TICKS(WT), .CNT_W(4), .PENALIZE_STRAY(0)) dut_n (
        .clk(clk), .rst(rst), .btn(btn), .note_spawn(spawn), .tick(tick),
        .noteAction(act_n), .noteSuccessState(succ_n), .in_window(win_n)
    );

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    // Reference model. For each lane it tracks whether a note is live and how
    // many ticks that note has seen. Index 0 models the stray-penalising
    // variant and index 1 models the ignoring variant.
    bit         m_live [2][LANES];
    int         m_ticks[2][LANES];
    logic [3:0] m_act  [2];
    logic [3:0] m_succ [2];
    logic [3:0] m_prev;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < LANES; i++) begin
                m_live[k][i]  = 1'b0;
                m_ticks[k][i] = 0;
            end
            m_act[k]  = '0;
            m_succ[k] = '0;
        end
        m_prev = '0;
    endtask

    task automatic judge(input int k, input int i, input bit ok);
        m_act[k][i]  = 1'b1;
        m_succ[k][i] = ok;
    endtask

    task automatic model_step(input logic [3:0] b, input logic [3:0] s, input logic t);
        logic [3:0] press;
        press = b & ~m_prev;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = '0;
            for (int i = 0; i < LANES; i++) begin
                if (!m_live[k][i]) begin
                    if (press[i] && s[i])       judge(k, i, 1'b1);
                    else if (s[i]) begin
                        m_live[k][i]  = 1'b1;
                        m_ticks[k][i] = 0;
                    end
                    else if (press[i] && k == 0) judge(k, i, 1'b0);
                end else begin
                    if (press[i]) begin
                        judge(k, i, 1'b1);
                        m_live[k][i]  = s[i];
                        m_ticks[k][i] = 0;
                    end else if (s[i]) begin
                        judge(k, i, 1'b0);
                        m_ticks[k][i] = 0;
                    end else if (t) begin
                        m_ticks[k][i]++;
                        if (m_ticks[k][i] == WT) begin
                            judge(k, i, 1'b0);
                            m_live[k][i] = 1'b0;
                        end
                    end
                end
            end
        end
        m_prev = b;
    endtask

    function automatic logic [3:0] m_win(input int k);
        logic [3:0] w;
        for (int i = 0; i < LANES; i++) w[i] = m_live[k][i];
        return w;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " P.noteAction"}, act_p, m_act[0]);
        chk({tag, " P.success"}, succ_p, m_succ[0]);
        chk({tag, " P.in_window"}, win_p, m_win(0));
        chk({tag, " N.noteAction"}, act_n, m_act[1]);
        chk({tag, " N.success"}, succ_n, m_succ[1]);
        chk({tag, " N.in_window"}, win_n, m_win(1));
    endtask

    // Drive the inputs, let one rising edge pass, and then compare against the
    // model.
    task automatic step(input logic [3:0] b, input logic [3:0] s, input logic t, input string tag);
        btn = b; spawn = s; tick = t;
        @(posedge clk);
        #1;
        model_step(b, s, t);
        check_model(tag);
    endtask

    typedef struct {
        logic [3:0] b;
        logic [3:0] s;
        logic       t;
        logic [3:0] ea;
        logic [3:0] es;
        logic [3:0] ew;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // Expected outputs of the stray-penalising instance after each edge.
        tbl[0]  = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001}; // spawn lane 0
        tbl[1]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001};
        tbl[4]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000}; // hit lane 0
        tbl[5]  = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000}; // held: no pulse
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000};
        tbl[7]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0001, 4'b0000}; // stray lane 2
        tbl[8]  = '{4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0001, 4'b0010}; // spawn lane 1
        tbl[9]  = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0011, 4'b0010}; // press+spawn in window
        tbl[10] = '{4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b0011, 4'b1010};
        tbl[11] = '{4'b0000, 4'b1000, 1'b0, 4'b1000, 4'b0011, 4'b1010}; // respawn: old miss
        tbl[12] = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 4'b1011, 4'b1010}; // press+spawn in window
        tbl[13] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1011, 4'b1010};
        tbl[14] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b1011, 4'b1010}; // press+spawn in IDLE
        tbl[15] = '{4'b0000, 4'b0101, 1'b0, 4'b0000, 4'b1011, 4'b1111};
        tbl[16] = '{4'b0101, 4'b0000, 1'b0, 4'b0101, 4'b1111, 4'b1010}; // two lanes hit together

        // Hold reset with every input asserted. All outputs must stay low.
        btn = 4'b1111; spawn = 4'b1111; tick = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst P.noteAction", act_p, 4'b0000);
            chk("rst P.success", succ_p, 4'b0000);
            chk("rst P.in_window", win_p, 4'b0000);
            chk("rst N.noteAction", act_n, 4'b0000);
        end
        btn = '0; spawn = '0; tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step(4'b0000, 4'b0000, 1'b0, "post-reset");

        for (int v = 0; v < 17; v++) begin
            step(tbl[v].b, tbl[v].s, tbl[v].t, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d tbl.noteAction", v), act_p, tbl[v].ea);
            chk($sformatf("vec%0d tbl.success", v), succ_p, tbl[v].es);
            chk($sformatf("vec%0d tbl.in_window", v), win_p, tbl[v].ew);
        end

        // Lanes 1 and 3 restarted their windows inside the table. Their miss
        // must land exactly on the 12th tick.
        for (int c = 1; c <= 11; c++) step(4'b0000, 4'b0000, 1'b1, $sformatf("exp13 t%0d", c));
        chk("exp13 still open", win_p & 4'b1010, 4'b1010);
        step(4'b0000, 4'b0000, 1'b1, "exp13 t12");
        chk("exp13 miss pulse", act_p, 4'b1010);
        chk("exp13 miss result", succ_p & 4'b1010, 4'b0000);
        step(4'b0000, 4'b0000, 1'b0, "exp13 after");
        chk("exp13 single pulse", act_p, 4'b0000);

        // A plain miss on lane 3.
        step(4'b0000, 4'b1000, 1'b0, "miss3 spawn");
        for (int c = 1; c <= 12; c++) step(4'b0000, 4'b0000, 1'b1, $sformatf("miss3 t%0d", c));
        chk("miss3 pulse", act_p, 4'b1000);
        chk("miss3 result", succ_p & 4'b1000, 4'b0000);

        // A press that arrives with the expiring tick is a hit, with no miss.
        step(4'b0000, 4'b0100, 1'b0, "late spawn");
        for (int c = 1; c <= 11; c++) step(4'b0000, 4'b0000, 1'b1, $sformatf("late t%0d", c));
        step(4'b0100, 4'b0000, 1'b1, "late press");
        chk("late hit pulse", act_p, 4'b0100);
        chk("late hit result", succ_p & 4'b0100, 4'b0100);
        step(4'b0000, 4'b0000, 1'b1, "late after");
        chk("late no miss", act_p, 4'b0000);

        // Randomized traffic, with both instances compared against the model.
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] b, s;
            b = btn;
            for (int i = 0; i < LANES; i++) begin
                if ($urandom_range(0, 3) == 0) b[i] = ~b[i];
                s[i] = ($urandom_range(0, 15) == 0);
            end
            step(b, s, ($urandom_range(0, 2) == 0), $sformatf("rand%0d", c));
        end

        // Assert reset asynchronously mid-window. The outputs must clear before
        // any clock edge.
        step(4'b0000, 4'b0000, 1'b0, "pre-arst");
        step(4'b0000, 4'b1111, 1'b0, "arst spawn");
        step(4'b0000, 4'b0000, 1'b1, "arst tick");
        chk("arst windows open", win_p, 4'b1111);
        rst = 1'b1;
        #2;
        chk("arst P.in_window", win_p, 4'b0000);
        chk("arst P.noteAction", act_p, 4'b0000);
        chk("arst N.in_window", win_n, 4'b0000);
        chk("arst P.success", succ_p, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 14; c++) step(4'b0000, 4'b0000, 1'b1, $sformatf("post-arst%0d", c));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
